// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared constants and types for the iterative AES round controller.
//   Key size is selected at build time:
//     AES_KEY_256 -> NK=8, NR=14
//     AES_KEY_192 -> NK=6, NR=12
//     (neither)   -> NK=4, NR=10  (AES-128)
//   Optional build macro used by the controller: AES_DECRYPT_EN.
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int WORD = 32;
   localparam int NB   = 4;

`ifdef AES_KEY_256
   localparam int NK = 8;
   localparam int NR = 14;
`elsif AES_KEY_192
   localparam int NK = 6;
   localparam int NR = 12;
`else
   localparam int NK = 4;
   localparam int NR = 10;
`endif

   // key-schedule word index and round counter widths
   localparam int KW     = $clog2(NB*(NR+1));
   localparam int RW     = $clog2(NR+1);
   localparam int RCON_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      KEXP,
      INIT,
      ROUND,
      FINAL,
      DONE
   } ctrl_state_t;

endpackage

// File: rtl/aes_kexp_seq.sv
// ---------------------------------------------------------------------------
// aes_kexp_seq
//   Key-expansion word sequencer. A start pulse arms it; from the next cycle
//   it steps the word index NK..NB*(NR+1)-1, one word per cycle, and decodes
//   the per-word transform selects from a mod-NK phase counter (no divider).
//   The index saturates on the last word.
// Ports
//   clk, rst_n   clock, async active-low reset
//   start        arm the sequence (first word appears next cycle)
//   we           a key word is written this cycle
//   idx          current word index
//   rot          idx % NK == 0 : RotWord + SubWord + Rcon
//   sub          NK > 6 && idx % NK == 4 : SubWord only
//   rcon_idx     idx / NK while rot, else 0
//   last_word    this cycle writes the final word
// ---------------------------------------------------------------------------
module aes_kexp_seq #(
   parameter int NB = 4,
   parameter int NK = 4,
   parameter int NR = 10,
   localparam int KW = $clog2(NB*(NR+1))
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       we,
   output logic [KW-1:0]              idx,
   output logic                       rot,
   output logic                       sub,
   output logic [aes_pkg::RCON_W-1:0] rcon_idx,
   output logic                       last_word
);
   import aes_pkg::*;

   localparam logic [KW-1:0]     IDX_FIRST = KW'(NK);
   localparam logic [KW-1:0]     IDX_LAST  = KW'(NB*(NR+1)-1);
   localparam logic [3:0]        PH_LAST   = 4'(NK-1);
   localparam logic [3:0]        PH_SUB    = 4'd4;
   localparam logic              HAS_SUB   = (NK > 6);

   logic              active;
   logic [KW-1:0]     idx_q;
   logic [3:0]        phase_q;
   logic [RCON_W-1:0] rcon_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= 1'b0;
         idx_q   <= '0;
         phase_q <= '0;
         rcon_q  <= '0;
      end else if (start) begin
         active  <= 1'b1;
         idx_q   <= IDX_FIRST;
         phase_q <= '0;
         rcon_q  <= RCON_W'(1);
      end else if (active) begin
         if (idx_q == IDX_LAST) begin
            active <= 1'b0;
         end else begin
            idx_q <= idx_q + 1'b1;
            if (phase_q == PH_LAST) begin
               phase_q <= '0;
               rcon_q  <= rcon_q + 1'b1;
            end else begin
               phase_q <= phase_q + 1'b1;
            end
         end
      end
   end

   // decodes gated by active so nothing strobes while idle or after reset
   assign we        = active;
   assign idx       = idx_q;
   assign rot       = active && (phase_q == '0);
   assign sub       = HAS_SUB && active && (phase_q == PH_SUB);
   assign rcon_idx  = rot ? rcon_q : '0;
   assign last_word = active && (idx_q == IDX_LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//   Sequencing controller for the iterative AES cipher datapath. Accepts a
//   block (optionally with a new key) by valid/ready, runs key expansion when
//   needed, then drives the round counter and per-round strobes, and holds the
//   finished block until downstream accepts it.
//   Build macro: AES_DECRYPT_EN adds in_dec / inv_round and a down-counting
//   round sequence.
// Ports
//   clk, rst_n             clock, async active-low reset
//   in_valid, in_key_new   block presented / key changed (sampled together)
//   in_ready               controller idle, can accept a block
//   out_valid, out_ready   finished block handshake
//   busy                   any state other than IDLE
//   load_state             datapath captures the input block (handshake cycle)
//   kexp_we/idx/rot/sub    key-schedule word write and transform selects
//   rcon_idx               Rcon index, valid with kexp_rot
//   round, round_en        current round, apply one round this cycle
//   first_round            AddRoundKey only
//   last_round             final round, MixColumns bypassed
//   in_dec, inv_round      (AES_DECRYPT_EN) decrypt request / inverse rounds
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a block
//   KEXP  | key expansion, one word per cycle
//   INIT  | initial AddRoundKey (first_round)
//   ROUND | middle rounds, counter steps each cycle
//   FINAL | final round without MixColumns (last_round)
//   DONE  | result held, waiting for out_ready
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
   parameter int NB = aes_pkg::NB,
   parameter int NK = aes_pkg::NK,
   parameter int NR = aes_pkg::NR,
   localparam int KW = $clog2(NB*(NR+1)),
   localparam int RW = $clog2(NR+1)
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic                       in_key_new,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       load_state,
   output logic                       kexp_we,
   output logic [KW-1:0]              kexp_idx,
   output logic                       kexp_rot,
   output logic                       kexp_sub,
   output logic [aes_pkg::RCON_W-1:0] rcon_idx,
   output logic [RW-1:0]              round,
   output logic                       round_en,
   output logic                       first_round,
   output logic                       last_round
`ifdef AES_DECRYPT_EN
   ,
   input  logic                       in_dec,
   output logic                       inv_round
`endif
);
   import aes_pkg::*;

   localparam logic [RW-1:0] R_ZERO   = '0;
   localparam logic [RW-1:0] R_ONE    = RW'(1);
   localparam logic [RW-1:0] R_PENULT = RW'(NR-1);
   localparam logic [RW-1:0] R_LAST   = RW'(NR);

   ctrl_state_t state;
   logic        key_loaded;
   logic        dec_q;
   logic        dec_in;
   logic        accept;
   logic        kexp_start;
   logic        kexp_last;

`ifdef AES_DECRYPT_EN
   assign dec_in    = in_dec;
   assign inv_round = dec_q;
`else
   assign dec_in    = 1'b0;
`endif

   // load_state is the handshake itself, so it cannot wait for a register
   assign accept     = (state == IDLE) && in_valid;
   assign load_state = accept;
   assign kexp_start = accept && (in_key_new || !key_loaded);

   aes_kexp_seq #(
      .NB (NB),
      .NK (NK),
      .NR (NR)
   ) u_kexp (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (kexp_start),
      .we        (kexp_we),
      .idx       (kexp_idx),
      .rot       (kexp_rot),
      .sub       (kexp_sub),
      .rcon_idx  (rcon_idx),
      .last_word (kexp_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         key_loaded  <= 1'b0;
         dec_q       <= 1'b0;
         in_ready    <= 1'b1;
         busy        <= 1'b0;
         out_valid   <= 1'b0;
         round       <= R_ZERO;
         round_en    <= 1'b0;
         first_round <= 1'b0;
         last_round  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
                  dec_q    <= dec_in;
                  if (kexp_start) begin
                     state <= KEXP;
                  end else begin
                     state       <= INIT;
                     round_en    <= 1'b1;
                     first_round <= 1'b1;
                     round       <= dec_in ? R_LAST : R_ZERO;
                  end
               end
            end
            KEXP: begin
               if (kexp_last) begin
                  key_loaded  <= 1'b1;
                  state       <= INIT;
                  round_en    <= 1'b1;
                  first_round <= 1'b1;
                  round       <= dec_q ? R_LAST : R_ZERO;
               end
            end
            INIT: begin
               first_round <= 1'b0;
               state       <= ROUND;
               round       <= dec_q ? R_PENULT : R_ONE;
            end
            ROUND: begin
               if (round == (dec_q ? R_ONE : R_PENULT)) begin
                  state      <= FINAL;
                  last_round <= 1'b1;
                  round      <= dec_q ? R_ZERO : R_LAST;
               end else begin
                  round <= dec_q ? (round - R_ONE) : (round + R_ONE);
               end
            end
            FINAL: begin
               last_round <= 1'b0;
               round_en   <= 1'b0;
               out_valid  <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               // in_ready only rises with the move to IDLE: no accept this cycle
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  round     <= R_ZERO;
                  dec_q     <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
